// File: rtl/lsu_mem_adapter_if.sv
// lsu_mem_adapter_if
// Groups the three handshakes of the load/store adapter into one bundle:
//   CPU request   : t_req_valid/t_req_ready, t_req_we, t_req_addr, t_req_size,
//                   t_req_unsigned, t_req_wdata
//   CPU response  : i_rsp_valid/i_rsp_ready, i_rsp_data, i_rsp_err
//   Memory request: i_mem_valid/t_mem_ready, i_mem_we, i_mem_addr, i_mem_data,
//                   i_mem_mask
//   Memory return : t_mem_valid/i_mem_ready, t_mem_data
// Modport "slave" is the adapter's view; "master" is the surrounding system.
interface lsu_mem_adapter_if #(
  parameter int AW = 15
);
  logic          t_req_valid;
  logic          t_req_ready;
  logic          t_req_we;
  logic [31:0]   t_req_addr;
  logic [1:0]    t_req_size;
  logic          t_req_unsigned;
  logic [31:0]   t_req_wdata;

  logic          i_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   i_rsp_data;
  logic          i_rsp_err;

  logic          i_mem_valid;
  logic          t_mem_ready;
  logic          i_mem_we;
  logic [AW-1:0] i_mem_addr;
  logic [31:0]   i_mem_data;
  logic [3:0]    i_mem_mask;

  logic          t_mem_valid;
  logic [31:0]   t_mem_data;
  logic          i_mem_ready;

  modport slave (
    input  t_req_valid, t_req_we, t_req_addr, t_req_size, t_req_unsigned, t_req_wdata,
    output t_req_ready,
    output i_rsp_valid, i_rsp_data, i_rsp_err,
    input  i_rsp_ready,
    output i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
    input  t_mem_ready,
    input  t_mem_valid, t_mem_data,
    output i_mem_ready
  );

  modport master (
    output t_req_valid, t_req_we, t_req_addr, t_req_size, t_req_unsigned, t_req_wdata,
    input  t_req_ready,
    input  i_rsp_valid, i_rsp_data, i_rsp_err,
    output i_rsp_ready,
    input  i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
    output t_mem_ready,
    output t_mem_valid, t_mem_data,
    input  i_mem_ready
  );
endinterface

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter
// Converts one CPU load/store request at a time into a word-wide memory
// access with byte-lane mask, and returns an aligned, extended load result.
// Ports:
//   clk  - single clock, rising edge
//   rstf - synchronous active-high reset
//   bus  - lsu_mem_adapter_if.slave (CPU request/response, memory request/return)
// Flow: IDLE -(legal)-> ISSUE -(store)-> RESP -> IDLE
//                             -(load)--> WAIT -> RESP
//       IDLE -(illegal)-> RESP (error response, no memory access)
module lsu_mem_adapter #(
  parameter int AW = 15
) (
  input logic               clk,
  input logic               rstf,
  lsu_mem_adapter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Misalignment, illegal size, or address beyond the memory.
  function automatic logic req_err(input logic [1:0] size, input logic [31:0] addr);
    logic bad_align;
    logic out_range;
    out_range = ((addr >> AW) != 32'd0);
    case (size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
    return bad_align | out_range;
  endfunction

  // Replicate right-aligned store data across the lanes it may land in.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Byte-enable mask selecting the addressed lanes.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << off;
      SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Pick the addressed lane(s) out of the returned word and extend.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic uns, input logic [31:0] data);
    logic [7:0]  lane;
    logic [15:0] half;
    logic [31:0] result;
    lane = data[{off, 3'b000} +: 8];
    half = off[1] ? data[31:16] : data[15:0];
    case (size)
      SZ_BYTE: result = {{24{~uns & lane[7]}}, lane};
      SZ_HALF: result = {{16{~uns & half[15]}}, half};
      default: result = data;
    endcase
    return result;
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    size_r;
  logic [1:0]    off_r;
  logic          uns_r;
  logic          mem_valid_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [31:0]   mem_data_r;
  logic [3:0]    mem_mask_r;
  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic [31:0]   rsp_data_r;

  logic          cap_err_s;
  logic [31:0]   load_data_s;

  // Request classification and load-data alignment from current inputs/registers.
  always_comb begin
    cap_err_s   = req_err(bus.t_req_size, bus.t_req_addr);
    load_data_s = load_extract(size_r, off_r, uns_r, bus.t_mem_data);
  end

  // Ready is withheld during reset so nothing is accepted on a reset edge.
  assign bus.t_req_ready = (state_r == IDLE) && !rstf;
  assign bus.i_mem_ready = (state_r == WAIT);
  assign bus.i_mem_valid = mem_valid_r;
  assign bus.i_mem_we    = mem_we_r;
  assign bus.i_mem_addr  = mem_addr_r;
  assign bus.i_mem_data  = mem_data_r;
  assign bus.i_mem_mask  = mem_mask_r;
  assign bus.i_rsp_valid = rsp_valid_r;
  assign bus.i_rsp_data  = rsp_data_r;
  assign bus.i_rsp_err   = rsp_err_r;

  // Transaction FSM with all bus-facing fields held in registers.
  always_ff @(posedge clk) begin
    if (rstf) begin
      state_r     <= IDLE;
      size_r      <= 2'd0;
      off_r       <= 2'd0;
      uns_r       <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_data_r  <= 32'd0;
      mem_mask_r  <= 4'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.t_req_valid) begin
            size_r <= bus.t_req_size;
            off_r  <= bus.t_req_addr[1:0];
            uns_r  <= bus.t_req_unsigned;
            if (cap_err_s) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= 32'd0;
              state_r     <= RESP;
            end else begin
              mem_valid_r <= 1'b1;
              mem_we_r    <= bus.t_req_we;
              mem_addr_r  <= {bus.t_req_addr[AW-1:2], 2'b00};
              // Loads read the full word; lane selection happens on return.
              mem_data_r  <= bus.t_req_we ? store_lanes(bus.t_req_size, bus.t_req_wdata) : 32'd0;
              mem_mask_r  <= bus.t_req_we ? store_mask(bus.t_req_size, bus.t_req_addr[1:0])
                                          : 4'b1111;
              state_r     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.t_mem_ready) begin
            mem_valid_r <= 1'b0;
            if (mem_we_r) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b0;
              rsp_data_r  <= 32'd0;
              state_r     <= RESP;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.t_mem_valid) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= load_data_s;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          mem_valid_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed testbench for lsu_mem_adapter. Inputs are driven and outputs
// sampled on the falling edge of clk.
module tb_lsu_mem_adapter;

  logic clk;
  logic rstf;
  int   checks;
  int   errors;

  lsu_mem_adapter_if #(.AW(15)) bus ();

  lsu_mem_adapter #(.AW(15)) dut (
    .clk  (clk),
    .rstf (rstf),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one request to completion with memory always ready and read data
  // returned the cycle after WAIT is entered. lat counts falling edges from
  // acceptance until i_rsp_valid is seen (bounded at 20).
  task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, input logic [31:0] mdata,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic saw_mem, output logic [14:0] m_addr,
                     output logic [31:0] m_data, output logic [3:0] m_mask, output logic m_we);
    saw_mem = 1'b0; m_addr = 15'd0; m_data = 32'd0; m_mask = 4'd0; m_we = 1'b0;
    bus.t_req_valid = 1'b1; bus.t_req_we = we; bus.t_req_addr = addr;
    bus.t_req_size = size; bus.t_req_unsigned = uns; bus.t_req_wdata = wdata;
    bus.t_mem_ready = 1'b1; bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    bus.t_req_valid = 1'b0;
    lat = 1;
    while (!bus.i_rsp_valid && lat < 20) begin
      if (bus.i_mem_valid) begin
        saw_mem = 1'b1; m_addr = bus.i_mem_addr; m_data = bus.i_mem_data;
        m_mask = bus.i_mem_mask; m_we = bus.i_mem_we;
      end
      bus.t_mem_valid = bus.i_mem_ready;
      bus.t_mem_data  = mdata;
      @(negedge clk);
      lat++;
    end
    bus.t_mem_valid = 1'b0;
    rdata = bus.i_rsp_data;
    err   = bus.i_rsp_err;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstf = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.t_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.t_req_ready); end
    checks++; if (bus.i_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", bus.i_mem_valid); end
    checks++; if (bus.i_rsp_valid !== 1'b0 || bus.i_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got valid %b err %b expected 0 0", bus.i_rsp_valid, bus.i_rsp_err); end
    checks++; if (bus.i_rsp_data !== 32'd0 || bus.i_mem_data !== 32'd0) begin errors++; $display("FAIL reset_data: got rsp %h mem %h expected 0 0", bus.i_rsp_data, bus.i_mem_data); end
    checks++; if (bus.i_mem_addr !== 15'd0 || bus.i_mem_mask !== 4'd0) begin errors++; $display("FAIL reset_addr_mask: got %h %b expected 0 0000", bus.i_mem_addr, bus.i_mem_mask); end
    rstf = 1'b0;
    @(negedge clk);
    checks++; if (bus.t_req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", bus.t_req_ready); end
    checks++; if (bus.i_mem_ready !== 1'b0) begin errors++; $display("FAIL idle_mem_ready: got %b expected 0", bus.i_mem_ready); end
  endtask

  task automatic test_store_byte();
    bus.t_req_valid = 1'b1; bus.t_req_we = 1'b1; bus.t_req_addr = 32'h0000_0006;
    bus.t_req_size = 2'd0; bus.t_req_unsigned = 1'b0; bus.t_req_wdata = 32'h0000_00A5;
    bus.t_mem_ready = 1'b1; bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    bus.t_req_valid = 1'b0;
    checks++; if (bus.i_mem_valid !== 1'b1 || bus.i_mem_we !== 1'b1) begin errors++; $display("FAIL sb_mem_valid_we: got %b %b expected 1 1", bus.i_mem_valid, bus.i_mem_we); end
    checks++; if (bus.i_mem_addr !== 15'h0004) begin errors++; $display("FAIL sb_addr: got %h expected 0004", bus.i_mem_addr); end
    checks++; if (bus.i_mem_mask !== 4'b0100) begin errors++; $display("FAIL sb_mask: got %b expected 0100", bus.i_mem_mask); end
    checks++; if (bus.i_mem_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_data: got %h expected a5a5a5a5", bus.i_mem_data); end
    checks++; if (bus.t_req_ready !== 1'b0) begin errors++; $display("FAIL sb_busy: got %b expected 0", bus.t_req_ready); end
    @(negedge clk);
    checks++; if (bus.i_rsp_valid !== 1'b1 || bus.i_mem_valid !== 1'b0) begin errors++; $display("FAIL sb_rsp_latency: got rsp %b mem %b expected 1 0", bus.i_rsp_valid, bus.i_mem_valid); end
    checks++; if (bus.i_rsp_err !== 1'b0 || bus.i_rsp_data !== 32'd0) begin errors++; $display("FAIL sb_rsp: got err %b data %h expected 0 0", bus.i_rsp_err, bus.i_rsp_data); end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    checks++; if (bus.i_rsp_valid !== 1'b0 || bus.t_req_ready !== 1'b1) begin errors++; $display("FAIL sb_done: got rsp %b ready %b expected 0 1", bus.i_rsp_valid, bus.t_req_ready); end
  endtask

  task automatic test_store_half_word();
    logic [31:0] rd; logic er; int lat; logic sm; logic [14:0] ma; logic [31:0] md; logic [3:0] mm; logic mw;
    txn(1'b1, 32'h0000_0012, 2'd1, 1'b0, 32'h1234_BEEF, 32'd0, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (ma !== 15'h0010 || mm !== 4'b1100 || md !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_fields: got %h %b %h expected 0010 1100 beefbeef", ma, mm, md); end
    checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL sh_latency: got %0d err %b expected 2 0", lat, er); end
    txn(1'b1, 32'h0000_0020, 2'd1, 1'b0, 32'h0000_1357, 32'd0, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (ma !== 15'h0020 || mm !== 4'b0011 || md !== 32'h1357_1357) begin errors++; $display("FAIL sh_low_fields: got %h %b %h expected 0020 0011 13571357", ma, mm, md); end
    txn(1'b1, 32'h0000_7FFC, 2'd2, 1'b0, 32'hCAFE_F00D, 32'd0, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (ma !== 15'h7FFC || mm !== 4'b1111 || md !== 32'hCAFE_F00D || mw !== 1'b1) begin errors++; $display("FAIL sw_fields: got %h %b %h %b expected 7ffc 1111 cafef00d 1", ma, mm, md, mw); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_top_rsp: got err %b data %h expected 0 0", er, rd); end
  endtask

  task automatic test_load();
    logic [31:0] rd; logic er; int lat; logic sm; logic [14:0] ma; logic [31:0] md; logic [3:0] mm; logic mw;
    txn(1'b0, 32'h0000_000A, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h8001_1234, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (rd !== 32'hFFFF_8001 || er !== 1'b0) begin errors++; $display("FAIL lh_signed: got %h err %b expected ffff8001 0", rd, er); end
    checks++; if (lat != 3) begin errors++; $display("FAIL lh_latency: got %0d expected 3", lat); end
    checks++; if (ma !== 15'h0008 || mm !== 4'b1111 || md !== 32'd0 || mw !== 1'b0) begin errors++; $display("FAIL ld_fields: got %h %b %h %b expected 0008 1111 0 0", ma, mm, md, mw); end
    txn(1'b0, 32'h0000_000A, 2'd1, 1'b1, 32'd0, 32'h8001_1234, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lh_unsigned: got %h expected 00008001", rd); end
    txn(1'b0, 32'h0000_0000, 2'd1, 1'b0, 32'd0, 32'h8001_7FFF, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (rd !== 32'h0000_7FFF) begin errors++; $display("FAIL lh_low_pos: got %h expected 00007fff", rd); end
    txn(1'b0, 32'h0000_0003, 2'd0, 1'b0, 32'd0, 32'h8000_0000, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
    txn(1'b0, 32'h0000_0001, 2'd0, 1'b1, 32'd0, 32'h0000_FE00, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (rd !== 32'h0000_00FE) begin errors++; $display("FAIL lb_unsigned: got %h expected 000000fe", rd); end
    txn(1'b0, 32'h0000_0008, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw: got %h expected deadbeef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; logic sm; logic [14:0] ma; logic [31:0] md; logic [3:0] mm; logic mw;
    txn(1'b0, 32'h0000_0002, 2'd2, 1'b0, 32'd0, 32'h1111_1111, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (er !== 1'b1 || rd !== 32'd0 || sm !== 1'b0) begin errors++; $display("FAIL misaligned_word: got err %b data %h mem %b expected 1 0 0", er, rd, sm); end
    checks++; if (lat != 1) begin errors++; $display("FAIL err_latency: got %0d expected 1", lat); end
    txn(1'b1, 32'h0000_0001, 2'd1, 1'b0, 32'h1234, 32'd0, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (er !== 1'b1 || sm !== 1'b0) begin errors++; $display("FAIL misaligned_half: got err %b mem %b expected 1 0", er, sm); end
    txn(1'b0, 32'h0000_0000, 2'd3, 1'b0, 32'd0, 32'h2222_2222, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (er !== 1'b1 || sm !== 1'b0) begin errors++; $display("FAIL illegal_size: got err %b mem %b expected 1 0", er, sm); end
    txn(1'b0, 32'h0000_8000, 2'd2, 1'b0, 32'd0, 32'h3333_3333, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (er !== 1'b1 || sm !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL out_of_range: got err %b mem %b data %h expected 1 0 0", er, sm, rd); end
    txn(1'b0, 32'h8000_0004, 2'd0, 1'b0, 32'd0, 32'h3333_3333, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (er !== 1'b1 || sm !== 1'b0) begin errors++; $display("FAIL out_of_range_hi: got err %b mem %b expected 1 0", er, sm); end
  endtask

  task automatic test_backpressure();
    bus.t_req_valid = 1'b1; bus.t_req_we = 1'b0; bus.t_req_addr = 32'h0000_0004;
    bus.t_req_size = 2'd2; bus.t_req_unsigned = 1'b0; bus.t_req_wdata = 32'd0;
    bus.t_mem_ready = 1'b0; bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    // Keep a second request pending; it must not be taken while busy.
    bus.t_req_addr = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.i_mem_valid !== 1'b1 || bus.i_mem_addr !== 15'h0004 || bus.i_mem_mask !== 4'b1111 || bus.t_req_ready !== 1'b0) begin errors++; $display("FAIL bp_mem_hold[%0d]: got v %b a %h m %b rdy %b expected 1 0004 1111 0", i, bus.i_mem_valid, bus.i_mem_addr, bus.i_mem_mask, bus.t_req_ready); end
      @(negedge clk);
    end
    checks++; if (bus.i_mem_valid !== 1'b1) begin errors++; $display("FAIL bp_mem_still: got %b expected 1", bus.i_mem_valid); end
    bus.t_mem_ready = 1'b1;
    @(negedge clk);
    bus.t_mem_ready = 1'b0;
    checks++; if (bus.i_mem_ready !== 1'b1 || bus.i_mem_valid !== 1'b0) begin errors++; $display("FAIL bp_wait: got mem_ready %b mem_valid %b expected 1 0", bus.i_mem_ready, bus.i_mem_valid); end
    bus.t_mem_valid = 1'b1; bus.t_mem_data = 32'h1122_3344;
    @(negedge clk);
    bus.t_mem_valid = 1'b0; bus.t_mem_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== 32'h1122_3344 || bus.i_rsp_err !== 1'b0 || bus.t_req_ready !== 1'b0) begin errors++; $display("FAIL bp_rsp_hold[%0d]: got v %b d %h e %b rdy %b expected 1 11223344 0 0", i, bus.i_rsp_valid, bus.i_rsp_data, bus.i_rsp_err, bus.t_req_ready); end
      if (i == 2) bus.i_rsp_ready = 1'b1;
      @(negedge clk);
    end
    bus.i_rsp_ready = 1'b0;
    bus.t_req_valid = 1'b0;
    checks++; if (bus.i_rsp_valid !== 1'b0 || bus.t_req_ready !== 1'b1 || bus.i_mem_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rsp %b rdy %b mem %b expected 0 1 0", bus.i_rsp_valid, bus.t_req_ready, bus.i_mem_valid); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat; logic sm; logic [14:0] ma; logic [31:0] md; logic [3:0] mm; logic mw;
    bus.t_req_valid = 1'b1; bus.t_req_we = 1'b0; bus.t_req_addr = 32'h0000_0010;
    bus.t_req_size = 2'd2; bus.t_req_unsigned = 1'b0;
    bus.t_mem_ready = 1'b1; bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    bus.t_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.i_mem_ready !== 1'b1) begin errors++; $display("FAIL rw_in_wait: got %b expected 1", bus.i_mem_ready); end
    rstf = 1'b1;
    @(negedge clk);
    checks++; if (bus.i_mem_ready !== 1'b0 || bus.i_rsp_valid !== 1'b0 || bus.t_req_ready !== 1'b0) begin errors++; $display("FAIL rw_reset: got mr %b rv %b rdy %b expected 0 0 0", bus.i_mem_ready, bus.i_rsp_valid, bus.t_req_ready); end
    rstf = 1'b0;
    bus.t_mem_valid = 1'b1; bus.t_mem_data = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.t_mem_valid = 1'b0;
    checks++; if (bus.i_rsp_valid !== 1'b0 || bus.t_req_ready !== 1'b1 || bus.i_rsp_data !== 32'd0) begin errors++; $display("FAIL rw_stray: got rv %b rdy %b d %h expected 0 1 0", bus.i_rsp_valid, bus.t_req_ready, bus.i_rsp_data); end
    @(negedge clk);
    checks++; if (bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_stray_late: got %b expected 0", bus.i_rsp_valid); end
    txn(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'd0, 32'h0000_55AA, rd, er, lat, sm, ma, md, mm, mw);
    checks++; if (rd !== 32'h0000_55AA || er !== 1'b0 || lat != 3) begin errors++; $display("FAIL rw_next_load: got %h err %b lat %0d expected 000055aa 0 3", rd, er, lat); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rstf = 1'b1;
    bus.t_req_valid = 1'b0; bus.t_req_we = 1'b0; bus.t_req_addr = 32'd0;
    bus.t_req_size = 2'd0; bus.t_req_unsigned = 1'b0; bus.t_req_wdata = 32'd0;
    bus.i_rsp_ready = 1'b0; bus.t_mem_ready = 1'b0;
    bus.t_mem_valid = 1'b0; bus.t_mem_data = 32'd0;
    test_reset();
    test_store_byte();
    test_store_half_word();
    test_load();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_adapter.md
LSU_MEM_ADAPTER -- requirements
Module: lsu_mem_adapter

Interface
REQ-001 Parameter AW, default 15, SHALL set the memory byte-address width (8192 words x 4 bytes).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstf  input  1  reset, synchronous and active-high (1 = reset), sampled on the rising edge of clk.
REQ-004 t_req_valid  input  1  CPU load/store request valid.
REQ-005 t_req_ready  output  1  adapter accepts a request this cycle.
REQ-006 t_req_we  input  1  1 = store, 0 = load.
REQ-007 t_req_addr  input  32  byte address.
REQ-008 t_req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 t_req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 t_req_wdata  input  32  store data, right-aligned.
REQ-011 i_rsp_valid / i_rsp_ready  output / input  1 / 1  response handshake.
REQ-012 i_rsp_data  output  32  aligned and extended load data; 0 for stores and errors.
REQ-013 i_rsp_err  output  1  misaligned, illegal size, or address at or above 2^AW.
REQ-014 i_mem_valid / t_mem_ready  output / input  1 / 1  memory request handshake.
REQ-015 i_mem_we, i_mem_addr[AW-1:0], i_mem_data[31:0], i_mem_mask[3:0]  output  memory request fields; i_mem_data is 4 byte lanes, lane k = bits 8k+7:8k.
REQ-016 t_mem_valid  input  1, t_mem_data  input  32, i_mem_ready  output  1  memory read return.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; reset state SHALL be IDLE.
REQ-018 t_req_ready SHALL equal (state == IDLE); a request SHALL be captured into registers when t_req_valid and t_req_ready are both 1.
REQ-019 Error check at capture: size 3, half with addr[0] = 1, word with addr[1:0] != 0, or addr[31:AW] != 0 -> IDLE to RESP with err = 1 and data = 0; no memory access.
REQ-020 Legal capture -> ISSUE. In ISSUE, i_mem_valid = 1 with fields driven from registers only, held stable until t_mem_ready = 1.
REQ-021 ISSUE with t_mem_ready = 1: a store goes to RESP; a load goes to WAIT.
REQ-022 i_mem_addr = {addr[AW-1:2], 2'b00}; i_mem_we = stored t_req_we.
REQ-023 Store lanes: byte -> wdata[7:0] replicated to all 4 lanes, mask = 1 << addr[1:0]; half -> wdata[15:0] replicated, mask 0011 (addr[1] = 0) or 1100 (addr[1] = 1); word -> wdata, mask 1111.
REQ-024 Load requests SHALL drive mask 1111 and i_mem_data = 0.
REQ-025 i_mem_ready SHALL equal (state == WAIT). In WAIT, t_mem_valid = 1 captures t_mem_data, then -> RESP.
REQ-026 Load extract: byte -> lane addr[1:0]; half -> bits [31:16] if addr[1] = 1, else [15:0]; then extend to 32 bits per t_req_unsigned. Word is passed through unchanged.
REQ-027 t_mem_valid outside WAIT SHALL be ignored.
REQ-028 In RESP, i_rsp_valid = 1 with data and err held stable until i_rsp_ready = 1, then -> IDLE; no new request SHALL be accepted in the same cycle.
REQ-029 Latency with memory ready at once and 1-cycle read data: load response valid 3 cycles after acceptance; store response 2 cycles; error response 1 cycle.
REQ-030 Exactly one outstanding request at a time; no reordering.

Reset
REQ-031 When rstf = 1: state = IDLE; i_mem_valid, i_rsp_valid, i_rsp_err = 0; i_rsp_data, i_mem_data, i_mem_addr, i_mem_mask = 0. Takes effect at the next edge in any state.
REQ-032 Reset during ISSUE or WAIT SHALL abandon the transaction; a late t_mem_valid after reset SHALL be ignored (REQ-027).
REQ-033 With rstf = 1, t_req_ready SHALL be 0.

Verification
REQ-034 Store byte: addr 0x0000_0006, wdata 0x0000_00A5 -> mem addr 0x0004, mask 0100, data 0xA5A5A5A5; response err = 0, data = 0.
REQ-035 Load half signed: addr 0x0000_000A, mem returns 0x8001_1234 -> rsp_data 0xFFFF_8001; with unsigned = 1 -> 0x0000_8001.
REQ-036 Misaligned word: addr 0x0000_0002, size 2 -> no i_mem_valid pulse; i_rsp_err = 1 one cycle after acceptance.
REQ-037 Backpressure: t_mem_ready held 0 for 3 cycles, then i_rsp_ready held 0 for 2 cycles -> mem and rsp fields stable throughout; t_req_ready = 0 until the response is accepted.
REQ-038 Out of range: addr 0x0000_8000 with AW = 15 -> err = 1, no memory access.
REQ-039 Reset while in WAIT, then a stray t_mem_valid -> IDLE, no i_rsp_valid; the next load completes normally.
